blob_tracker: RTL and testbench

Parametrised multi-class blob tracker for the VGA pixel stream, and the next generation of the single-class orange classifier. It counts per-class hit pixels and their horizontal position sum on every active pixel. At each frame boundary it evaluates the selected class. It reports presence, with frame-persistence hysteresis, and a left/centre/right direction for the LEDs and the IR/mic-driven control logic.

---
 rtl/blob_tracker_pkg.sv | 29 ++
 rtl/blob_accumulator.sv | 34 +++
 rtl/blob_tracker.sv | 152 +++++++++++++++
 tb/tb_blob_tracker.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/blob_tracker_pkg.sv
// Shared types and width helpers for the multi-class blob tracker.
package blob_tracker_pkg;

  typedef enum logic [1:0] {
    DIR_NONE   = 2'b00,
    DIR_LEFT   = 2'b01,
    DIR_RIGHT  = 2'b10,
    DIR_CENTRE = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    MUL   = 2'd1,
    CMP   = 2'd2
  } state_t;

  function automatic int cnt_width(input int h, input int v);
    return $clog2(h * v + 1);
  endfunction

  function automatic int sum_width(input int h, input int v);
    return $clog2(longint'(h) * longint'(v) * longint'(h));
  endfunction

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/blob_accumulator.sv
// One per-class hit counter and x-position sum, cleared at each frame snapshot.
module blob_accumulator #(
  parameter int CNT_W = 19,
  parameter int SUM_W = 28,
  parameter int X_W   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             hit,
  input  logic [X_W-1:0]   x,
  output logic [CNT_W-1:0] cnt,
  output logic [SUM_W-1:0] sum
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A hit coinciding with the clear belongs to the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sum <= '0;
    end else if (clr) begin
      cnt <= hit ? CNT_W'(1) : '0;
      sum <= hit ? SUM_W'(x) : '0;
    end else if (hit) begin
      cnt <= sat_inc(cnt);
      sum <= sum + SUM_W'(x);
    end
  end

endmodule

// File: rtl/blob_tracker.sv
// Multi-class blob tracker: per-class accumulation, frame snapshot, and a
// two-cycle evaluation producing presence (with persistence) and direction.
module blob_tracker
  import blob_tracker_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int N_CLASSES   = 2,
  parameter int MIN_PIXELS  = 200,
  parameter int PERSIST     = 3,
  parameter int LEFT_BOUND  = 213,
  parameter int RIGHT_BOUND = 427,
  localparam int CNT_W      = cnt_width(H_ACTIVE, V_ACTIVE),
  localparam int SEL_W      = sel_width(N_CLASSES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pix_valid,
  input  logic                 vsync_n,
  input  logic [N_CLASSES-1:0] class_hit,
  input  logic [SEL_W-1:0]     class_sel,
  input  logic                 fast,
  output logic                 detected,
  output logic [1:0]           direction,
  output logic                 frame_done,
  output logic [CNT_W-1:0]     hit_count
);

  localparam int SUM_W = sum_width(H_ACTIVE, V_ACTIVE);
  localparam int X_W   = $clog2(H_ACTIVE);
  localparam int RUN_W = $clog2(PERSIST + 1);

  logic             pix_valid_q, vsync_q, snap, line_end, primed;
  logic [X_W-1:0]   x_cnt;
  logic [CNT_W-1:0] cnt_a [N_CLASSES];
  logic [SUM_W-1:0] sum_a [N_CLASSES];
  state_t           state, state_nx;

  assign snap     = vsync_q & ~vsync_n;
  assign line_end = pix_valid_q & ~pix_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid_q <= 1'b0;
      vsync_q     <= 1'b1;
      x_cnt       <= '0;
    end else begin
      pix_valid_q <= pix_valid;
      vsync_q     <= vsync_n;
      if (snap || line_end) x_cnt <= '0;
      else if (pix_valid)   x_cnt <= x_cnt + 1'b1;
    end
  end

  for (genvar c = 0; c < N_CLASSES; c++) begin : g_acc
    blob_accumulator #(.CNT_W(CNT_W), .SUM_W(SUM_W), .X_W(X_W)) u_acc (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (snap),
      .hit  (pix_valid & class_hit[c]),
      .x    (x_cnt),
      .cnt  (cnt_a[c]),
      .sum  (sum_a[c])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ACCUM;
      primed <= 1'b0;
    end else begin
      state <= state_nx;
      if (snap) primed <= 1'b1;
    end
  end

  // The very first snapshot only primes; a snapshot during MUL/CMP is ignored.
  always_comb begin
    state_nx = state;
    unique case (state)
      ACCUM:   if (snap && primed) state_nx = MUL;
      MUL:     state_nx = CMP;
      CMP:     state_nx = ACCUM;
      default: state_nx = ACCUM;
    endcase
  end

  // Stage p0: frame snapshot of the selected class
  logic [CNT_W-1:0] ev_cnt_p0;
  logic [SUM_W-1:0] ev_sum_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_cnt_p0 <= '0;
      ev_sum_p0 <= '0;
    end else if (state == ACCUM && snap && primed) begin
      ev_cnt_p0 <= cnt_a[class_sel];
      ev_sum_p0 <= sum_a[class_sel];
    end
  end

  // Stage p1: bound products, compared against the sum instead of dividing
  logic [SUM_W-1:0] prod_l_p1, prod_r_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_l_p1 <= '0;
      prod_r_p1 <= '0;
    end else if (state == MUL) begin
      prod_l_p1 <= SUM_W'(ev_cnt_p0) * SUM_W'(LEFT_BOUND);
      prod_r_p1 <= SUM_W'(ev_cnt_p0) * SUM_W'(RIGHT_BOUND);
    end
  end

  // Stage p2: persistence and direction decision
  logic [RUN_W-1:0] run, run_nx, p_eff;
  logic             seen, det_nx;
  dir_t             dir_nx;

  always_comb begin
    p_eff  = fast ? RUN_W'(1) : RUN_W'(PERSIST);
    seen   = ev_cnt_p0 >= CNT_W'(MIN_PIXELS);
    run_nx = '0;
    if (seen) run_nx = (run >= p_eff) ? p_eff : run + 1'b1;
    det_nx = seen && (run_nx == p_eff);
    dir_nx = DIR_NONE;
    if (det_nx) begin
      if (ev_sum_p0 < prod_l_p1)       dir_nx = DIR_LEFT;
      else if (ev_sum_p0 >= prod_r_p1) dir_nx = DIR_RIGHT;
      else                             dir_nx = DIR_CENTRE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run        <= '0;
      detected   <= 1'b0;
      direction  <= DIR_NONE;
      frame_done <= 1'b0;
      hit_count  <= '0;
    end else begin
      frame_done <= (state == CMP);
      if (state == CMP) begin
        run       <= run_nx;
        detected  <= det_nx;
        direction <= dir_nx;
        hit_count <= ev_cnt_p0;
      end
    end
  end

endmodule

// File: tb/tb_blob_tracker.sv
// Scoreboard bench for blob_tracker: stimulus tasks queue hand-computed results,
// a monitor pops and compares them on every frame_done.
module tb_blob_tracker;
  import blob_tracker_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_valid = 1'b0;
  logic        vsync_n = 1'b1;
  logic        fast = 1'b0;
  logic [1:0]  class_hit = 2'b00;
  logic [0:0]  class_sel = 1'b0;
  logic        detected;
  logic [1:0]  direction;
  logic        frame_done;
  logic [18:0] hit_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic       det;
    logic [1:0] dir;
    int         hc;
    int         at;
  } exp_t;
  exp_t q[$];

  blob_tracker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_valid (pix_valid),
    .vsync_n   (vsync_n),
    .class_hit (class_hit),
    .class_sel (class_sel),
    .fast      (fast),
    .detected  (detected),
    .direction (direction),
    .frame_done(frame_done),
    .hit_count (hit_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && frame_done) begin
      exp_t e;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        check("detected", int'(detected), int'(e.det));
        check("direction", int'(direction), int'(e.dir));
        check("hit_count", int'(hit_count), e.hc);
        check("latency_cycle", cyc, e.at);
      end
    end
  end

  task automatic line(input int lo0, input int hi0, input int lo1, input int hi1, input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      pix_valid    = 1'b1;
      class_hit[0] = (i >= lo0) && (i <= hi0);
      class_hit[1] = (i >= lo1) && (i <= hi1);
    end
    @(negedge clk);
    pix_valid = 1'b0;
    class_hit = 2'b00;
    @(negedge clk);
  endtask

  task automatic frame(input int n, input int lo0, input int hi0, input int lo1, input int hi1,
                       input int len);
    repeat (n) line(lo0, hi0, lo1, hi1, len);
  endtask

  task automatic vsync(input bit ev, input logic det, input logic [1:0] dir, input int hc);
    exp_t e;
    @(negedge clk);
    vsync_n = 1'b0;
    if (ev) begin
      e.det = det;
      e.dir = dir;
      e.hc  = hc;
      e.at  = cyc + 3;
      q.push_back(e);
    end
    @(negedge clk);
    @(negedge clk);
    vsync_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_detected"}, int'(detected), 0);
    check({tag, "_direction"}, int'(direction), 0);
    check({tag, "_hit_count"}, int'(hit_count), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog_timeout actual=cycle_%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("reset");

    // First frame is discarded, second empty frame evaluates to all zero
    frame(2, 1, 0, 1, 0, 20);
    vsync(1'b0, 1'b0, DIR_NONE, 0);
    frame(2, 1, 0, 1, 0, 20);
    vsync(1'b1, 1'b0, DIR_NONE, 0);

    // 300 px at x=100..109, persistence 3
    repeat (2) begin
      frame(30, 100, 109, 1, 0, 110);
      vsync(1'b1, 1'b0, DIR_NONE, 300);
    end
    frame(30, 100, 109, 1, 0, 110);
    vsync(1'b1, 1'b1, DIR_LEFT, 300);

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("async_reset_idle");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fast mode: first evaluated frame already detects
    fast = 1'b1;
    vsync(1'b0, 1'b0, DIR_NONE, 0);
    frame(30, 100, 109, 1, 0, 110);
    vsync(1'b1, 1'b1, DIR_LEFT, 300);

    frame(20, 300, 309, 1, 0, 310);
    vsync(1'b1, 1'b1, DIR_CENTRE, 200);
    frame(20, 500, 509, 1, 0, 510);
    vsync(1'b1, 1'b1, DIR_RIGHT, 200);

    // Centroid exactly 212 / 213 / 426 / 427
    frame(1, 112, 312, 1, 0, 313);
    vsync(1'b1, 1'b1, DIR_LEFT, 201);
    frame(1, 113, 313, 1, 0, 314);
    vsync(1'b1, 1'b1, DIR_CENTRE, 201);
    frame(1, 326, 526, 1, 0, 527);
    vsync(1'b1, 1'b1, DIR_CENTRE, 201);
    frame(1, 327, 527, 1, 0, 528);
    vsync(1'b1, 1'b1, DIR_RIGHT, 201);

    // One below the minimum after a detected run
    frame(1, 0, 198, 1, 0, 199);
    vsync(1'b1, 1'b0, DIR_NONE, 199);

    // Class 0 sees 50 px, class 1 sees 250 px
    class_sel = 1'b0;
    frame(1, 0, 49, 0, 249, 250);
    vsync(1'b1, 1'b0, DIR_NONE, 50);
    class_sel = 1'b1;
    frame(1, 0, 49, 0, 249, 250);
    vsync(1'b1, 1'b1, DIR_LEFT, 250);

    // Reset while the FSM is in MUL
    frame(1, 0, 49, 0, 249, 250);
    @(negedge clk);
    vsync_n = 1'b0;
    @(negedge clk);
    rst_n   = 1'b0;
    vsync_n = 1'b1;
    #1;
    check_zero("reset_in_mul");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_zero("after_mul_reset");

    check("pending_expectations", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
